// File: rtl/obi_mem_responder.sv
// ----------------------------------------------------------------------------
// obi_mem_responder
//   Dual-port OBI memory slave used as the instruction/data memory of
//   cv32e40p core benches. The fetch port is read-only, the data port reads
//   and writes with byte enables. A side-band preload port writes whole words
//   (by word index) and blocks both grants while active.
//
//   Each port answers every accepted request after a fixed latency, in
//   request order, through its own shift pipe. Each port caps how many
//   requests it has accepted but not yet answered. Optional LFSR-driven stalls
//   withhold the grant at random.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   instr_req_i / instr_gnt_o     fetch handshake (grant is combinational)
//   instr_addr_i                  fetch byte address
//   instr_rvalid_o/instr_rdata_o  fetch response
//   data_req_i / data_gnt_o       data handshake (grant is combinational)
//   data_we_i, data_be_i          write strobe and byte enables
//   data_addr_i, data_wdata_i     data byte address, write data
//   data_rvalid_o/data_rdata_o    data response (rdata is 0 for writes)
//   load_en_i, load_addr_i,
//   load_data_i                   preload strobe, word index, word
// ----------------------------------------------------------------------------

// Per-port handshake control: grant, outstanding count, stall LFSR and the
// fixed-latency response pipe.
module obi_port_ctrl #(
  parameter int unsigned RVALID_LATENCY  = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          GNT_STALL_EN    = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'h0001
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        load_en_i,
  input  logic [31:0] resp_data_i,
  output logic        gnt_o,
  output logic        acc_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned   CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [15:0]                     lfsr_q, lfsr_d;
  logic                            stall;
  logic [CW-1:0]                   outst_q, outst_d;
  logic                            retire;
  logic [RVALID_LATENCY-1:0]       vld_q, vld_d;
  logic [RVALID_LATENCY-1:0][31:0] dat_q, dat_d;
  logic [31:0]                     resp_word;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign stall  = GNT_STALL_EN && (lfsr_q[1:0] == 2'b00);

  assign gnt_o     = req_i & ~load_en_i & ~stall & (outst_q < MAX_C);
  assign acc_o     = req_i & gnt_o;
  assign resp_word = acc_o ? resp_data_i : 32'h0;

  // A request stops counting as outstanding on the edge that raises its
  // rvalid, so MAX_OUTSTANDING >= RVALID_LATENCY sustains one accept per cycle.
  generate
    if (RVALID_LATENCY == 1) begin : g_lat1
      assign vld_d  = acc_o;
      assign dat_d  = resp_word;
      assign retire = acc_o;
    end else begin : g_latn
      assign vld_d  = {vld_q[RVALID_LATENCY-2:0], acc_o};
      assign dat_d  = {dat_q[RVALID_LATENCY-2:0], resp_word};
      assign retire = vld_q[RVALID_LATENCY-2];
    end
  endgenerate

  always_comb begin
    outst_d = outst_q;
    if (acc_o && !retire) begin
      outst_d = outst_q + CW'(1);
    end else if (!acc_o && retire) begin
      outst_d = outst_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q  <= LFSR_SEED;
      outst_q <= '0;
      vld_q   <= '0;
      dat_q   <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      outst_q <= outst_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  assign rvalid_o = vld_q[RVALID_LATENCY-1];
  assign rdata_o  = vld_q[RVALID_LATENCY-1] ? dat_q[RVALID_LATENCY-1] : 32'h0;

endmodule

module obi_mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 16384,
  parameter int unsigned RVALID_LATENCY  = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          GNT_STALL_EN    = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // A zero seed would lock an LFSR at zero, i.e. stall forever.
  localparam logic [15:0] SEED_I     = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] SEED_D_RAW = SEED_I ^ 16'hA5A5;
  localparam logic [15:0] SEED_D     = (SEED_D_RAW == 16'h0) ? 16'h0001 : SEED_D_RAW;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] instr_idx, data_idx, load_idx;
  logic [31:0]   instr_word, data_word;
  logic          instr_acc, data_acc;
  logic          unused_bits;

  // Upper address bits are dropped, so accesses wrap modulo the memory size.
  assign instr_idx = instr_addr_i[AW+1:2];
  assign data_idx  = data_addr_i[AW+1:2];
  assign load_idx  = load_addr_i[AW-1:0];

  // Reads sample the array before this edge's write lands (read-before-write).
  assign instr_word = mem_q[instr_idx];
  assign data_word  = data_we_i ? 32'h0 : mem_q[data_idx];

  obi_port_ctrl #(
    .RVALID_LATENCY (RVALID_LATENCY),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .GNT_STALL_EN   (GNT_STALL_EN),
    .LFSR_SEED      (SEED_I)
  ) u_instr_port (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (instr_req_i),
    .load_en_i  (load_en_i),
    .resp_data_i(instr_word),
    .gnt_o      (instr_gnt_o),
    .acc_o      (instr_acc),
    .rvalid_o   (instr_rvalid_o),
    .rdata_o    (instr_rdata_o)
  );

  obi_port_ctrl #(
    .RVALID_LATENCY (RVALID_LATENCY),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .GNT_STALL_EN   (GNT_STALL_EN),
    .LFSR_SEED      (SEED_D)
  ) u_data_port (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (data_req_i),
    .load_en_i  (load_en_i),
    .resp_data_i(data_word),
    .gnt_o      (data_gnt_o),
    .acc_o      (data_acc),
    .rvalid_o   (data_rvalid_o),
    .rdata_o    (data_rdata_o)
  );

  // Memory contents survive reset. Preload and data writes never coincide
  // because preload forces the data grant low.
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem_q[load_idx] <= load_data_i;
    end else if (data_acc && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[data_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign unused_bits = ^{instr_addr_i, data_addr_i, load_addr_i, instr_acc};

endmodule
